// File: rtl/contador_pkg.sv
// Shared types and defaults for the cork counter: BCD digit type, debounce state encoding,
// default timing constants and a two-digit BCD increment helper.
package contador_pkg;

    localparam int unsigned BCD_W            = 4;
    localparam int unsigned NUM_DIGITOS      = 4;
    localparam int unsigned SCAN_DIV_DEF     = 50000;
    localparam int unsigned DEBOUNCE_DEF     = 1000;
    localparam int unsigned ROLHAS_DUZIA_DEF = 12;

    typedef logic [BCD_W-1:0] bcd_t;

    typedef enum logic [1:0] {
        EST_0  = 2'd0,
        CONF_1 = 2'd1,
        EST_1  = 2'd2,
        CONF_0 = 2'd3
    } estado_deb_t;

    // Returns {dezenas, unidades} incremented by one; callers never pass 99.
    function automatic logic [2*BCD_W-1:0] incr_bcd2(input bcd_t dez, input bcd_t uni);
        if (uni == bcd_t'(9)) begin
            return {bcd_t'(dez + bcd_t'(1)), bcd_t'(0)};
        end
        return {dez, bcd_t'(uni + bcd_t'(1))};
    endfunction

endpackage

// File: rtl/filtro_sensor.sv
// Cork sensor front end: two-flop synchronizer followed by a debounce FSM that emits a
// single-cycle event only when a confirmed rising level is accepted.
module filtro_sensor
    import contador_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic sensor,
    output logic evento
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    estado_deb_t   estado;
    logic [CW-1:0] cnt_estavel;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_1      <= 1'b0;
            sync_2      <= 1'b0;
            estado      <= EST_0;
            cnt_estavel <= '0;
            evento      <= 1'b0;
        end else begin
            sync_1 <= sensor;
            sync_2 <= sync_1;
            evento <= 1'b0;
            case (estado)
                EST_0: begin
                    if (sync_2) begin
                        estado      <= CONF_1;
                        cnt_estavel <= '0;
                    end
                end
                CONF_1: begin
                    if (!sync_2) begin
                        estado <= EST_0;
                    end else if (cnt_estavel == CNT_MAX) begin
                        estado <= EST_1;
                        evento <= 1'b1;
                    end else begin
                        cnt_estavel <= cnt_estavel + 1'b1;
                    end
                end
                EST_1: begin
                    if (!sync_2) begin
                        estado      <= CONF_0;
                        cnt_estavel <= '0;
                    end
                end
                CONF_0: begin
                    if (sync_2) begin
                        estado <= EST_1;
                    end else if (cnt_estavel == CNT_MAX) begin
                        estado <= EST_0;
                    end else begin
                        cnt_estavel <= cnt_estavel + 1'b1;
                    end
                end
                default: estado <= EST_0;
            endcase
        end
    end

endmodule

// File: rtl/contador_rolhas_bcd.sv
// Cork counter feeding the 4-digit multiplexed display: debounced cork events are packed into
// dozens as registered BCD digits, alongside a free-running digit-scan select.
module contador_rolhas_bcd
    import contador_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = SCAN_DIV_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int unsigned ROLHAS_DUZIA    = ROLHAS_DUZIA_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sensor_rolha,
    input  logic       ligado,
    input  logic       zerar,
    output logic [1:0] contador,
    output bcd_t       duzias_dezenas,
    output bcd_t       duzias_unidades,
    output bcd_t       rolhas_dezenas,
    output bcd_t       rolhas_unidades,
    output logic       duzia_completa,
    output logic       cheio
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
    localparam bcd_t ROL_DEZ_MAX = bcd_t'((ROLHAS_DUZIA - 1) / 10);
    localparam bcd_t ROL_UNI_MAX = bcd_t'((ROLHAS_DUZIA - 1) % 10);

    logic             evento;
    logic [DIV_W-1:0] div_scan;
    logic             rolhas_no_max;
    logic             duzias_no_max;

    filtro_sensor #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filtro (
        .clock (clock),
        .reset (reset),
        .sensor(sensor_rolha),
        .evento(evento)
    );

    always_comb begin
        rolhas_no_max = (rolhas_dezenas == ROL_DEZ_MAX) && (rolhas_unidades == ROL_UNI_MAX);
        duzias_no_max = (duzias_dezenas == bcd_t'(9)) && (duzias_unidades == bcd_t'(9));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_scan <= '0;
            contador <= 2'd0;
        end else if (div_scan == DIV_MAX) begin
            div_scan <= '0;
            contador <= contador + 2'd1;
        end else begin
            div_scan <= div_scan + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            duzias_dezenas  <= '0;
            duzias_unidades <= '0;
            rolhas_dezenas  <= '0;
            rolhas_unidades <= '0;
            duzia_completa  <= 1'b0;
            cheio           <= 1'b0;
        end else begin
            duzia_completa <= 1'b0;
            if (zerar) begin
                duzias_dezenas  <= '0;
                duzias_unidades <= '0;
                rolhas_dezenas  <= '0;
                rolhas_unidades <= '0;
                cheio           <= 1'b0;
            end else if (evento && ligado && !cheio) begin
                if (!rolhas_no_max) begin
                    {rolhas_dezenas, rolhas_unidades} <= incr_bcd2(rolhas_dezenas, rolhas_unidades);
                end else if (duzias_no_max) begin
                    // Saturated: keep 99/11 on display and latch full.
                    cheio <= 1'b1;
                end else begin
                    rolhas_dezenas  <= '0;
                    rolhas_unidades <= '0;
                    {duzias_dezenas, duzias_unidades} <= incr_bcd2(duzias_dezenas, duzias_unidades);
                    duzia_completa  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_contador_rolhas_bcd.sv
// Bench for contador_rolhas_bcd: integer-level model of debounce, counting and scan, compared
// against every output each cycle, plus hand-computed literal expectations.
module tb_contador_rolhas_bcd;

    localparam int DC = 4;
    localparam int SD = 3;
    localparam int RD = 12;

    logic       clock;
    logic       reset;
    logic       sensor_rolha;
    logic       ligado;
    logic       zerar;
    logic [1:0] contador;
    logic [3:0] duzias_dezenas;
    logic [3:0] duzias_unidades;
    logic [3:0] rolhas_dezenas;
    logic [3:0] rolhas_unidades;
    logic       duzia_completa;
    logic       cheio;

    int total = 0;
    int bad   = 0;
    bit checking = 0;

    contador_rolhas_bcd #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_CYCLES(DC),
        .ROLHAS_DUZIA   (RD)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .sensor_rolha   (sensor_rolha),
        .ligado         (ligado),
        .zerar          (zerar),
        .contador       (contador),
        .duzias_dezenas (duzias_dezenas),
        .duzias_unidades(duzias_unidades),
        .rolhas_dezenas (rolhas_dezenas),
        .rolhas_unidades(rolhas_unidades),
        .duzia_completa (duzia_completa),
        .cheio          (cheio)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", nome, act, exp, $time);
        end
    endtask

    // Model: sensor delayed two cycles; accepted level flips after DC+1 equal differing samples.
    logic m_s1, m_s2, m_acc, m_ev, m_pulse, m_cheio;
    int   m_run, m_doz, m_rol, m_scan_n;

    always @(posedge clock) begin : modelo
        int nrun;
        if (reset) begin
            m_s1 <= 0; m_s2 <= 0; m_acc <= 0; m_ev <= 0; m_run <= 0;
            m_doz <= 0; m_rol <= 0; m_cheio <= 0; m_pulse <= 0; m_scan_n <= 0;
        end else begin
            m_s1 <= sensor_rolha;
            m_s2 <= m_s1;
            m_scan_n <= m_scan_n + 1;
            if (m_s2 != m_acc) begin
                nrun = m_run + 1;
                if (nrun == DC + 1) begin
                    m_acc <= m_s2;
                    m_run <= 0;
                    m_ev  <= m_s2;
                end else begin
                    m_run <= nrun;
                    m_ev  <= 0;
                end
            end else begin
                m_run <= 0;
                m_ev  <= 0;
            end
            m_pulse <= 0;
            if (zerar) begin
                m_doz <= 0; m_rol <= 0; m_cheio <= 0;
            end else if (m_ev && ligado && !m_cheio) begin
                if (m_rol != RD - 1) m_rol <= m_rol + 1;
                else if (m_doz == 99) m_cheio <= 1;
                else begin
                    m_rol <= 0; m_doz <= m_doz + 1; m_pulse <= 1;
                end
            end
        end
    end

    int dc_seen = 0;
    always @(negedge clock) begin : comparador
        logic [19:0] exp_v, act_v;
        if (checking) begin
            exp_v = {2'((m_scan_n / SD) % 4), 4'(m_doz / 10), 4'(m_doz % 10),
                     4'(m_rol / 10), 4'(m_rol % 10), m_pulse, m_cheio};
            act_v = {contador, duzias_dezenas, duzias_unidades, rolhas_dezenas,
                     rolhas_unidades, duzia_completa, cheio};
            check("saidas_vs_modelo", 32'(act_v), 32'(exp_v));
            if (duzia_completa) dc_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulso(input int hi, input int lo);
        sensor_rolha = 1'b1;
        tick(hi);
        sensor_rolha = 1'b0;
        tick(lo);
    endtask

    task automatic limpa();
        zerar = 1'b1;
        tick(1);
        zerar = 1'b0;
        tick(2);
    endtask

    initial begin : estimulo
        logic [1:0] scan_exp [12];
        int dc_base;
        scan_exp = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
        sensor_rolha = 0; ligado = 1; zerar = 0; reset = 1;
        @(posedge clock);
        #1;
        checking = 1;
        tick(1);
        reset = 0;

        // Scan select after reset, then idle outputs.
        for (int k = 0; k < 12; k++) begin
            tick(1);
            check("scan_seq", 32'(contador), 32'(scan_exp[k]));
        end
        tick(8);
        check("idle_digitos", {16'd0, duzias_dezenas, duzias_unidades, rolhas_dezenas,
              rolhas_unidades}, 32'd0);
        check("idle_flags", {30'd0, duzia_completa, cheio}, 32'd0);

        // Short glitch, then one clean long pulse.
        pulso(3, 12);
        check("glitch_sem_contagem", 32'(rolhas_unidades), 32'd0);
        pulso(10, 12);
        check("pulso_limpo", 32'(rolhas_unidades), 32'd1);
        tick(10);
        check("pulso_unico", 32'(rolhas_unidades), 32'd1);

        // One dozen.
        limpa();
        dc_base = dc_seen;
        for (int p = 0; p < 10; p++) pulso(8, 8);
        check("rolhas_10", {24'd0, rolhas_dezenas, rolhas_unidades}, 32'h10);
        pulso(8, 8);
        check("rolhas_11", {24'd0, rolhas_dezenas, rolhas_unidades}, 32'h11);
        pulso(8, 8);
        check("duzia_fechada", {16'd0, duzias_dezenas, duzias_unidades, rolhas_dezenas,
              rolhas_unidades}, 32'h0100);
        check("duzia_completa_uma_vez", 32'(dc_seen - dc_base), 32'd1);

        // Saturation at 99/11.
        limpa();
        for (int p = 0; p < 1199; p++) pulso(7, 7);
        check("pre_saturacao", {15'd0, cheio, duzias_dezenas, duzias_unidades, rolhas_dezenas,
              rolhas_unidades}, 32'h9911);
        dc_base = dc_seen;
        pulso(7, 7);
        check("saturado", {15'd0, cheio, duzias_dezenas, duzias_unidades, rolhas_dezenas,
              rolhas_unidades}, 32'h19911);
        pulso(7, 7);
        check("saturado_mantem", {15'd0, cheio, duzias_dezenas, duzias_unidades, rolhas_dezenas,
              rolhas_unidades}, 32'h19911);
        check("saturado_sem_duzia", 32'(dc_seen - dc_base), 32'd0);

        // Counting disabled, and re-enable while sensor held high.
        limpa();
        check("zerar_limpa_cheio", 32'(cheio), 32'd0);
        pulso(8, 8);
        pulso(8, 8);
        ligado = 0;
        for (int p = 0; p < 3; p++) pulso(8, 8);
        check("desligado_congela", 32'(rolhas_unidades), 32'd2);
        sensor_rolha = 1;
        tick(10);
        ligado = 1;
        tick(10);
        sensor_rolha = 0;
        tick(10);
        check("religado_sem_contagem", 32'(rolhas_unidades), 32'd2);
        pulso(8, 8);
        check("religado_proximo", 32'(rolhas_unidades), 32'd3);

        // zerar on the same cycle the event would count.
        limpa();
        for (int p = 0; p < 5; p++) pulso(8, 8);
        check("rolhas_05", {24'd0, rolhas_dezenas, rolhas_unidades}, 32'h05);
        sensor_rolha = 1;
        for (int i = 0; i < 40 && !m_ev; i++) tick(1);
        check("evento_alcancado", 32'(m_ev), 32'd1);
        zerar = 1;
        tick(1);
        zerar = 0;
        check("zerar_vence_evento", {15'd0, cheio, duzias_dezenas, duzias_unidades,
              rolhas_dezenas, rolhas_unidades}, 32'd0);
        tick(3);
        sensor_rolha = 0;
        tick(12);
        pulso(8, 8);
        check("apos_zerar_conta", 32'(rolhas_unidades), 32'd1);

        // Reset while confirming a rise.
        sensor_rolha = 1;
        tick(4);
        reset = 1;
        sensor_rolha = 0;
        tick(2);
        reset = 0;
        tick(20);
        check("reset_meio_conf", {16'd0, duzias_dezenas, duzias_unidades, rolhas_dezenas,
              rolhas_unidades}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
